// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control sequencer: a Moore FSM with registered controls,
// memory-ready stalls with timeout, sticky traps and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zf,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic [1:0]       pc_source,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_RD    = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WR    = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_ADDI_EXEC = 4'd9,
        S_ADDI_WB   = 4'd10,
        S_BEQ       = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
    } ctl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [7:0] WAIT_LAST     = 8'(WAIT_MAX - 1);

    state_t     cur;
    state_t     nxt;
    ctl_t       ctl;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    logic [1:0] cause_nxt;
    logic       retire;
    logic       waiting;
    logic       expired;

    // The branch decision on zf is made in the datapath; the sequencer only raises pc_write_cond.
    logic zf_unused;
    assign zf_unused = zf;

    // Moore control word for a given state; outputs are registered from the next state.
    function automatic ctl_t ctl_for(state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 3'b010;
            end
            S_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            S_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_ADDI_WB:  c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 3'b001;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
            end
            S_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    assign waiting = (cur == S_FETCH) || (cur == S_MEM_RD) || (cur == S_MEM_WR);
    assign expired = !mem_ready && (wait_cnt == WAIT_LAST);

    always_comb begin
        nxt       = cur;
        cause_nxt = 2'b00;
        retire    = 1'b0;
        // Counter is zero everywhere except while stalling, which also clears it on entry.
        wait_nxt  = (waiting && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
        case (cur)
            S_IDLE: nxt = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (cur == S_FETCH) begin
                        nxt = S_DECODE;
                    end else if (cur == S_MEM_RD) begin
                        nxt = S_MEM_WB;
                    end else begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                end else if (expired) begin
                    nxt       = S_TRAP;
                    cause_nxt = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: nxt = S_MEM_ADDR;
                    OP_RTYPE:     nxt = S_R_EXEC;
                    OP_ADDI:      nxt = S_ADDI_EXEC;
                    OP_BEQ:       nxt = S_BEQ;
                    OP_J:         nxt = S_JUMP;
                    default: begin
                        nxt       = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_R_EXEC:    nxt = S_R_WB;
            S_ADDI_EXEC: nxt = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_ADDI_WB, S_BEQ, S_JUMP: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            S_TRAP:  nxt = S_TRAP;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur         <= S_IDLE;
            ctl         <= '0;
            wait_cnt    <= 8'd0;
            trap        <= 1'b0;
            trap_cause  <= 2'b00;
            instr_count <= '0;
        end else begin
            cur      <= nxt;
            ctl      <= ctl_for(nxt);
            wait_cnt <= wait_nxt;
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (nxt == S_TRAP && cur != S_TRAP) begin
                trap       <= 1'b1;
                trap_cause <= cause_nxt;
            end
        end
    end

    // Fetch completes in the cycle mem_ready is seen, so IR/PC loads are gated by it directly.
    assign ir_write      = (cur == S_FETCH) && mem_ready;
    assign pc_write      = ctl.pc_write || ((cur == S_FETCH) && mem_ready);
    assign pc_write_cond = ctl.pc_write_cond;
    assign pc_source     = ctl.pc_source;
    assign i_or_d        = ctl.i_or_d;
    assign mem_read      = ctl.mem_read;
    assign mem_write     = ctl.mem_write;
    assign reg_dst       = ctl.reg_dst;
    assign mem_to_reg    = ctl.mem_to_reg;
    assign reg_write     = ctl.reg_write;
    assign alu_src_a     = ctl.alu_src_a;
    assign alu_src_b     = ctl.alu_src_b;
    assign alu_op        = ctl.alu_op;
    assign state         = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected state, control word and
// status are queued as stimulus is driven and compared when the DUT output settles.
module tb_multicycle_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zf;
    logic             mem_ready;
    logic             pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic             reg_dst, mem_to_reg, reg_write, alu_src_a, trap;
    logic [1:0]       pc_source, alu_src_b, trap_cause;
    logic [2:0]       alu_op;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [16:0] ctl;
        logic [34:0] sts;
    } exp_t;

    exp_t sb[$];

    logic        exp_trap;
    logic [1:0]  exp_cause;
    logic [31:0] exp_cnt;

    multicycle_ctrl #(.WAIT_MAX(15), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zf(zf), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
        .trap(trap), .trap_cause(trap_cause), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    // Control word order: pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
    // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op
    function automatic logic [16:0] exp_ctl(logic [3:0] s, logic rdy);
        logic pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa;
        logic [1:0] psrc, asb;
        logic [2:0] aop;
        {pw, pwc, iod, mr, mw, irw, rd, m2r, rw, asa} = '0;
        psrc = 2'b00; asb = 2'b00; aop = 3'b000;
        case (s)
            4'd1:  begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
            4'd2:  asb = 2'b11;
            4'd3:  begin asa = 1; asb = 2'b10; end
            4'd4:  begin mr = 1; iod = 1; end
            4'd5:  begin rw = 1; m2r = 1; end
            4'd6:  begin mw = 1; iod = 1; end
            4'd7:  begin asa = 1; aop = 3'b010; end
            4'd8:  begin rw = 1; rd = 1; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: rw = 1;
            4'd11: begin asa = 1; aop = 3'b001; pwc = 1; psrc = 2'b01; end
            4'd12: begin pw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pw, pwc, psrc, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop};
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        logic [16:0] obs_ctl;
        if (sb.size() == 0) begin
            check_val("scoreboard_empty", 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        obs_ctl = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op};
        check_val({e.tag, ".state"}, 64'(state), 64'(e.st));
        check_val({e.tag, ".ctl"}, 64'(obs_ctl), 64'(e.ctl));
        check_val({e.tag, ".status"}, 64'({trap, trap_cause, instr_count}), 64'(e.sts));
    endtask

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic cycle(input string tag, input logic [5:0] op, input logic rdy,
                         input logic z, input logic [3:0] est, input logic ret);
        exp_t e;
        e.tag = tag;
        e.st  = est;
        e.ctl = exp_ctl(est, rdy);
        e.sts = {exp_trap, exp_cause, exp_cnt};
        sb.push_back(e);
        opcode = op; mem_ready = rdy; zf = z;
        #1;
        compare_out();
        if (ret) exp_cnt++;
        @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        exp_t e;
        exp_trap = 0; exp_cause = 2'b00; exp_cnt = 0;
        e.tag = tag; e.st = 4'd0; e.ctl = '0; e.sts = '0;
        sb.push_back(e);
        mem_ready = 0;
        rst_n = 0;
        #1;
        compare_out();
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; opcode = 6'd0; zf = 0; mem_ready = 0;
        exp_trap = 0; exp_cause = 2'b00; exp_cnt = 0;
        @(negedge clk);
        @(negedge clk);
        reset_check("rst0");

        // R-type: 0,1,2,7,8
        cycle("r.idle", 6'b000000, 1, 0, 4'd0, 0);
        cycle("r.fetch", 6'b000000, 1, 0, 4'd1, 0);
        cycle("r.dec", 6'b000000, 1, 0, 4'd2, 0);
        cycle("r.exec", 6'b000000, 1, 0, 4'd7, 0);
        cycle("r.wb", 6'b000000, 1, 0, 4'd8, 1);

        // lw with three wait cycles in MEM_RD
        cycle("lw.fetch", 6'b100011, 1, 0, 4'd1, 0);
        cycle("lw.dec", 6'b100011, 1, 0, 4'd2, 0);
        cycle("lw.addr", 6'b100011, 1, 0, 4'd3, 0);
        for (int i = 0; i < 3; i++) cycle("lw.rdwait", 6'b100011, 0, 0, 4'd4, 0);
        cycle("lw.rd", 6'b100011, 1, 0, 4'd4, 0);
        cycle("lw.wb", 6'b100011, 1, 0, 4'd5, 1);

        // sw, zero wait
        cycle("sw.fetch", 6'b101011, 1, 0, 4'd1, 0);
        cycle("sw.dec", 6'b101011, 1, 0, 4'd2, 0);
        cycle("sw.addr", 6'b101011, 1, 0, 4'd3, 0);
        cycle("sw.wr", 6'b101011, 1, 0, 4'd6, 1);

        // addi
        cycle("addi.fetch", 6'b001000, 1, 0, 4'd1, 0);
        cycle("addi.dec", 6'b001000, 1, 0, 4'd2, 0);
        cycle("addi.exec", 6'b001000, 1, 0, 4'd9, 0);
        cycle("addi.wb", 6'b001000, 1, 0, 4'd10, 1);

        // beq taken then not taken
        for (int k = 1; k >= 0; k--) begin
            cycle("beq.fetch", 6'b000100, 1, 1'(k), 4'd1, 0);
            cycle("beq.dec", 6'b000100, 1, 1'(k), 4'd2, 0);
            cycle("beq.exec", 6'b000100, 1, 1'(k), 4'd11, 1);
        end

        // jump, with mem_ready low outside the memory states
        cycle("j.fetch", 6'b000010, 1, 0, 4'd1, 0);
        cycle("j.dec", 6'b000010, 0, 0, 4'd2, 0);
        cycle("j.exec", 6'b000010, 0, 0, 4'd12, 1);

        // illegal opcode -> sticky trap
        cycle("ill.fetch", 6'b111111, 1, 0, 4'd1, 0);
        cycle("ill.dec", 6'b111111, 1, 0, 4'd2, 0);
        exp_trap = 1; exp_cause = 2'b01;
        for (int i = 0; i < 20; i++)
            cycle("ill.trap", 6'b111111, 1'($urandom_range(0, 1)), 0, 4'd13, 0);
        reset_check("rst_after_ill");

        // fetch timeout after 15 waiting cycles
        cycle("to.idle", 6'b000000, 0, 0, 4'd0, 0);
        for (int i = 0; i < 15; i++) cycle("to.fetchwait", 6'b000000, 0, 0, 4'd1, 0);
        exp_trap = 1; exp_cause = 2'b10;
        for (int i = 0; i < 3; i++) cycle("to.trap", 6'b000000, 1, 0, 4'd13, 0);
        reset_check("rst_after_to");

        // mem_ready on the 15th waiting cycle wins
        cycle("nto.idle", 6'b000000, 0, 0, 4'd0, 0);
        for (int i = 0; i < 14; i++) cycle("nto.fetchwait", 6'b000000, 0, 0, 4'd1, 0);
        cycle("nto.fetch", 6'b000000, 1, 0, 4'd1, 0);
        cycle("nto.dec", 6'b000000, 1, 0, 4'd2, 0);
        cycle("nto.exec", 6'b000000, 1, 0, 4'd7, 0);
        cycle("nto.wb", 6'b000000, 1, 0, 4'd8, 1);
        cycle("nto.next", 6'b000000, 0, 0, 4'd1, 0);

        // sw with store timeout in MEM_WR
        cycle("swto.fetch", 6'b101011, 1, 0, 4'd1, 0);
        cycle("swto.dec", 6'b101011, 1, 0, 4'd2, 0);
        cycle("swto.addr", 6'b101011, 1, 0, 4'd3, 0);
        for (int i = 0; i < 15; i++) cycle("swto.wait", 6'b101011, 0, 0, 4'd6, 0);
        exp_trap = 1; exp_cause = 2'b10;
        cycle("swto.trap", 6'b101011, 1, 0, 4'd13, 0);

        // reset mid-instruction aborts
        reset_check("rst_mid");
        cycle("mid.idle", 6'b100011, 1, 0, 4'd0, 0);
        cycle("mid.fetch", 6'b100011, 1, 0, 4'd1, 0);
        cycle("mid.dec", 6'b100011, 1, 0, 4'd2, 0);
        reset_check("rst_abort");
        cycle("mid.idle2", 6'b100011, 1, 0, 4'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
